chunk_serializer: RTL

//  Parametrised multi-buffer serializer: accepts wide data chunks and replays each as a

---
 rtl/chunk_serializer.sv | 101 ++++++++++
 1 files changed

// File: rtl/chunk_serializer.sv
// chunk_serializer: ring of NUM_BUFS wide chunk buffers replayed as narrow words.
// In: clk, rstn, i_valid/i_data/i_last (chunk), i_oready (word accept).
// Out: o_req (space), o_data/o_ready/o_last (word), o_chunk_done, o_done, o_level.
module chunk_serializer #(
  parameter int BYTE              = 8,
  parameter int I_DATA_CHUNK_SIZE = 1024,
  parameter int O_DATA_CHUNK_SIZE = 8,
  parameter int NUM_BUFS          = 2,
  parameter bit WORD_REVERSE      = 1'b0,
  localparam int WORDS = I_DATA_CHUNK_SIZE / O_DATA_CHUNK_SIZE,
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1,
  localparam int CNT_W = $clog2(NUM_BUFS + 1)
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              i_valid,
  input  logic [I_DATA_CHUNK_SIZE*BYTE-1:0] i_data,
  input  logic                              i_last,
  output logic                              o_req,
  output logic [O_DATA_CHUNK_SIZE*BYTE-1:0] o_data,
  output logic                              o_ready,
  input  logic                              i_oready,
  output logic                              o_last,
  output logic                              o_chunk_done,
  output logic                              o_done,
  output logic [CNT_W-1:0]                  o_level
);

  localparam int IW    = I_DATA_CHUNK_SIZE * BYTE;
  localparam int OW    = O_DATA_CHUNK_SIZE * BYTE;
  localparam int PTR_W = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_BUFS - 1);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(NUM_BUFS);

  logic [IW-1:0]       bufs [NUM_BUFS];
  logic [NUM_BUFS-1:0] lastf;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [IDX_W-1:0] word_idx;
  logic [CNT_W-1:0] count;

  logic             accept;
  logic             xfer;
  logic             fin;
  logic [IDX_W-1:0] sel;
  logic [IW-1:0]    cur;

  assign o_req   = (count != FULL);
  assign o_ready = (count != '0);
  assign o_level = count;

  assign accept = i_valid & o_req;
  assign xfer   = o_ready & i_oready;
  assign fin    = xfer & (word_idx == LAST_IDX);

  assign sel    = WORD_REVERSE ? (LAST_IDX - word_idx) : word_idx;
  assign cur    = bufs[rd_ptr];
  assign o_data = cur[OW*sel +: OW];
  assign o_last = o_ready & lastf[rd_ptr] & (word_idx == LAST_IDX);

  // Payload storage carries no reset; o_ready masks stale contents.
  always_ff @(posedge clk) begin
    if (accept) begin
      bufs[wr_ptr]  <= i_data;
      lastf[wr_ptr] <= i_last;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      word_idx     <= '0;
      count        <= '0;
      o_chunk_done <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      o_chunk_done <= fin;
      o_done       <= fin & lastf[rd_ptr];
      if (accept) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (xfer) begin
        word_idx <= fin ? '0 : word_idx + 1'b1;
      end
      if (fin) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      // Accept and final-word retire in one cycle cancel out.
      unique case ({accept, fin})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
